// File: rtl/char_to_bin_pkg.sv
// Shared constants, types and unit-suffix decoder for the char_to_bin string parser.
package char_to_bin_pkg;

    localparam int NUM_CHARS = 16;

    localparam logic [2:0] UNIT_NONE = 3'd0;
    localparam logic [2:0] UNIT_HZ   = 3'd1;
    localparam logic [2:0] UNIT_NS   = 3'd2;
    localparam logic [2:0] UNIT_US   = 3'd6;
    localparam logic [2:0] UNIT_PCT  = 3'd7;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_BAD    = 2'd1;
    localparam logic [1:0] ERR_OVF    = 2'd2;
    localparam logic [1:0] ERR_DIGITS = 2'd3;

    localparam logic [7:0] CH_SPACE      = 8'h20;
    localparam logic [7:0] CH_UNDERSCORE = 8'h5F;
    localparam logic [7:0] CH_H          = 8'h48;
    localparam logic [7:0] CH_Z          = 8'h7A;
    localparam logic [7:0] CH_N          = 8'h6E;
    localparam logic [7:0] CH_U          = 8'h75;
    localparam logic [7:0] CH_S          = 8'h73;
    localparam logic [7:0] CH_PCT        = 8'h25;
    localparam logic [7:0] CH_ASCII_0    = 8'h30;
    localparam logic [7:0] CH_ASCII_9    = 8'h39;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT = 2'd0,
        CLS_SEP   = 2'd1,
        CLS_UNIT  = 2'd2,
        CLS_BAD   = 2'd3
    } char_class_t;

    typedef struct packed {
        logic [31:0] value;
        logic [2:0]  pattern;
        logic        err;
        logic [1:0]  err_code;
    } c2b_rsp_t;

    typedef struct packed {
        logic       bad;
        logic [2:0] code;
    } unit_dec_t;

    // Unit register holds the last two letters, oldest in the upper byte.
    function automatic unit_dec_t decode_unit(input logic [15:0] u);
        unit_dec_t r;
        r.bad  = 1'b0;
        r.code = UNIT_NONE;
        case (u)
            {CH_H, CH_Z}:    r.code = UNIT_HZ;
            {CH_N, CH_S}:    r.code = UNIT_NS;
            {CH_U, CH_S}:    r.code = UNIT_US;
            {8'h00, CH_PCT}: r.code = UNIT_PCT;
            16'h0000:        r.code = UNIT_NONE;
            default:         r.bad  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/char_to_bin_classify.sv
// Combinational byte classifier: digit / separator / unit letter / bad.
// CHAR_TO_BIN_ASCII_DIGIT_EN additionally accepts ASCII '0'..'9' as digits.
module char_classify
    import char_to_bin_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_t cls,
    output logic [3:0]  digit
);

    always_comb begin
        cls   = CLS_BAD;
        digit = 4'd0;
        if (ch <= 8'h09) begin
            cls   = CLS_DIGIT;
            digit = ch[3:0];
        end
`ifdef CHAR_TO_BIN_ASCII_DIGIT_EN
        else if (ch >= CH_ASCII_0 && ch <= CH_ASCII_9) begin
            cls   = CLS_DIGIT;
            digit = ch[3:0];
        end
`endif
        else if (ch == CH_SPACE || ch == CH_UNDERSCORE) begin
            cls = CLS_SEP;
        end
        else if (ch == CH_H || ch == CH_Z || ch == CH_N ||
                 ch == CH_U || ch == CH_S || ch == CH_PCT) begin
            cls = CLS_UNIT;
        end
    end

endmodule

// File: rtl/char_to_bin.sv
// Iterative 16-char display string -> 32-bit value + unit code, one char per clock.
// Optional CHAR_TO_BIN_ASCII_DIGIT_EN (in char_classify) accepts ASCII digits.
module char_to_bin
    import char_to_bin_pkg::*;
#(
    parameter int MAX_DIGITS = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         start,
    input  logic [127:0] char_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  value,
    output logic [2:0]   pattern,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam logic [4:0] MAX_DIG = 5'(MAX_DIGITS);

    state_t                         state;
    logic [NUM_CHARS-1:0][7:0]      shadow;
    logic [3:0]                     idx;
    logic [31:0]                    acc;
    logic [4:0]                     dig_cnt;
    logic [15:0]                    unit_reg;
    logic [1:0]                     unit_cnt;
    logic [1:0]                     err_q;
    c2b_rsp_t                       rsp_q;

    char_class_t cls;
    logic [3:0]  digit;
    logic [35:0] acc_x10;
    logic [4:0]  dig_cnt_nxt;
    logic [1:0]  char_err;
    unit_dec_t   unit_dec;

    char_classify u_classify (
        .ch    (shadow[idx]),
        .cls   (cls),
        .digit (digit)
    );

    // Wide enough that anything above 32 bits is visible as overflow.
    always_comb begin
        acc_x10     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + 36'(digit);
        dig_cnt_nxt = dig_cnt + 5'd1;
        char_err    = ERR_NONE;
        case (cls)
            CLS_DIGIT: begin
                if (unit_cnt != 2'd0)            char_err = ERR_BAD;
                else if (dig_cnt_nxt > MAX_DIG)  char_err = ERR_DIGITS;
                else if (acc_x10[35:32] != 4'd0) char_err = ERR_OVF;
            end
            CLS_UNIT: if (unit_cnt == 2'd2) char_err = ERR_BAD;
            CLS_SEP:  char_err = ERR_NONE;
            default:  char_err = ERR_BAD;
        endcase
    end

    assign unit_dec = decode_unit(unit_reg);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            shadow   <= '0;
            idx      <= 4'd0;
            acc      <= 32'd0;
            dig_cnt  <= 5'd0;
            unit_reg <= 16'd0;
            unit_cnt <= 2'd0;
            err_q    <= ERR_NONE;
            rsp_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow   <= char_in;
                        acc      <= 32'd0;
                        idx      <= 4'd15;
                        dig_cnt  <= 5'd0;
                        unit_reg <= 16'd0;
                        unit_cnt <= 2'd0;
                        err_q    <= ERR_NONE;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cls == CLS_DIGIT) begin
                        acc     <= acc_x10[31:0];
                        dig_cnt <= dig_cnt_nxt;
                    end
                    if (cls == CLS_UNIT && unit_cnt != 2'd2) begin
                        unit_reg <= {unit_reg[7:0], shadow[idx]};
                        unit_cnt <= unit_cnt + 2'd1;
                    end
                    // First error wins; scanning still runs all 16 chars.
                    if (err_q == ERR_NONE) err_q <= char_err;
                    idx <= idx - 4'd1;
                    if (idx == 4'd0) state <= ST_FINISH;
                end
                ST_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                    if (err_q == ERR_NONE && !unit_dec.bad) begin
                        rsp_q.value    <= acc;
                        rsp_q.pattern  <= unit_dec.code;
                        rsp_q.err      <= 1'b0;
                        rsp_q.err_code <= ERR_NONE;
                    end else begin
                        rsp_q.value    <= 32'd0;
                        rsp_q.pattern  <= UNIT_NONE;
                        rsp_q.err      <= 1'b1;
                        rsp_q.err_code <= (err_q == ERR_NONE) ? ERR_BAD : err_q;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign value    = rsp_q.value;
    assign pattern  = rsp_q.pattern;
    assign err      = rsp_q.err;
    assign err_code = rsp_q.err_code;

endmodule

// File: tb/tb_char_to_bin.sv
// Self-checking bench for char_to_bin: MAX_DIGITS=8 and =10 instances share stimulus.
module tb_char_to_bin;

`ifdef CHAR_TO_BIN_ASCII_DIGIT_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] char_in = '0;

    logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [31:0] value_a, value_b;
    logic [2:0]  pattern_a, pattern_b;
    logic [1:0]  ec_a, ec_b;
    logic [37:0] res_a, res_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    char_to_bin #(.MAX_DIGITS(8)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .char_in(char_in),
        .busy(busy_a), .done(done_a), .value(value_a), .pattern(pattern_a),
        .err(err_a), .err_code(ec_a)
    );

    char_to_bin #(.MAX_DIGITS(10)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .char_in(char_in),
        .busy(busy_b), .done(done_b), .value(value_b), .pattern(pattern_b),
        .err(err_b), .err_code(ec_b)
    );

    assign res_a = {value_a, pattern_a, err_a, ec_a};
    assign res_b = {value_b, pattern_b, err_b, ec_b};

    function automatic logic [37:0] pack_ok(input logic [31:0] v, input logic [2:0] p);
        return {v, p, 1'b0, 2'd0};
    endfunction

    function automatic logic [37:0] pack_err(input logic [1:0] c);
        return {32'd0, 3'd0, 1'b1, c};
    endfunction

    // Reference: walk the string left to right with plain integer arithmetic
    // and a text suffix, then map the suffix text to its unit code.
    function automatic logic [37:0] model(input logic [127:0] ci, input int maxd);
        longint      v = 0;
        int          nd = 0;
        int          ec = 0;
        int          d;
        int          p = 0;
        string       u = "";
        logic [7:0]  c;
        for (int k = 15; k >= 0; k--) begin
            c = ci[8*k +: 8];
            d = -1;
            if (c <= 8'd9) d = int'(c);
            else if (ASCII_EN && c >= 8'd48 && c <= 8'd57) d = int'(c) - 48;
            if (d >= 0) begin
                nd++;
                if (u.len() != 0) begin
                    if (ec == 0) ec = 1;
                end else if (nd > maxd) begin
                    if (ec == 0) ec = 3;
                end else if (ec == 0) begin
                    v = v * 10 + longint'(d);
                    if (v > 64'hFFFF_FFFF) ec = 2;
                end
            end else if (c == 8'h20 || c == 8'h5F) begin
                d = -1;
            end else if (c == 8'h48 || c == 8'h7A || c == 8'h6E || c == 8'h75 ||
                         c == 8'h73 || c == 8'h25) begin
                if (u.len() == 2) begin
                    if (ec == 0) ec = 1;
                end else begin
                    u = $sformatf("%s%c", u, c);
                end
            end else if (ec == 0) begin
                ec = 1;
            end
        end
        if (ec == 0) begin
            if (u == "") p = 0;
            else if (u == "Hz") p = 1;
            else if (u == "ns") p = 2;
            else if (u == "us") p = 6;
            else if (u == "%") p = 7;
            else ec = 1;
        end
        if (ec != 0) return pack_err(2'(ec));
        return pack_ok(v[31:0], 3'(p));
    endfunction

    // Caller sits #1 after an edge; start is sampled at the next edge (E0).
    task automatic run_conv(input logic [127:0] ci, output int lat, output int bcnt,
                            output logic d0);
        start   = 1'b1;
        char_in = ci;
        @(posedge clk); #1;
        start = 1'b0;
        d0    = done_a;
        lat   = -1;
        bcnt  = busy_a ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                lat = i;
                break;
            end
            if (busy_a) bcnt++;
        end
    endtask

    localparam logic [127:0] S_HZ   = {"  ", 8'h00, 8'h01, "_", 8'h02, 8'h03, 8'h04, "_",
                                       8'h05, 8'h06, 8'h07, "Hz  "};
    localparam logic [127:0] S_US   = {"  ", 8'h00, 8'h00, "_", 8'h00, 8'h00, 8'h00, "_",
                                       8'h00, 8'h04, 8'h02, "us  "};
    localparam logic [127:0] S_PCT  = {"  ", 8'h00, 8'h00, "_", 8'h00, 8'h00, 8'h00, "_",
                                       8'h00, 8'h04, 8'h02, "%   "};
    localparam logic [127:0] S_SP   = {"                "};
    localparam logic [127:0] S_NS   = {"  ", 8'h09, 8'h09, "_", 8'h09, 8'h09, 8'h09, "_",
                                       8'h09, 8'h09, 8'h09, "ns  "};
    localparam logic [127:0] S_BADA = {"  ", 8'h09, 8'h09, "_", 8'h09, 8'h41, 8'h09, "_",
                                       8'h09, 8'h09, 8'h09, "ns  "};
    localparam logic [127:0] S_HZD  = {"  ", 8'h01, 8'h02, "_", 8'h03, 8'h04, 8'h05, "_",
                                       "Hz", 8'h05, "   "};
    localparam logic [127:0] S_N10  = {"   ", {10{8'h09}}, "   "};
    localparam logic [127:0] S_MAX  = {"   ", 8'h04, 8'h02, 8'h09, 8'h04, 8'h09, 8'h06,
                                       8'h07, 8'h02, 8'h09, 8'h05, "   "};
    localparam logic [127:0] S_ASC  = {"      ", "12345678Hz"};

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, res_a} !== 40'd0) begin
            errors++;
            $display("FAIL reset_a: got %h required 0", {busy_a, done_a, res_a});
        end
        checks++;
        if ({busy_b, done_b, res_b} !== 40'd0) begin
            errors++;
            $display("FAIL reset_b: got %h required 0", {busy_b, done_b, res_b});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        logic [127:0] vec [8];
        logic [37:0]  exp [8];
        int lat, bcnt;
        logic d0;
        vec[0] = S_HZ;   exp[0] = pack_ok(32'd1234567, 3'd1);
        vec[1] = S_US;   exp[1] = pack_ok(32'd42, 3'd6);
        vec[2] = S_PCT;  exp[2] = pack_ok(32'd42, 3'd7);
        vec[3] = S_SP;   exp[3] = pack_ok(32'd0, 3'd0);
        vec[4] = S_NS;   exp[4] = pack_ok(32'd99999999, 3'd2);
        vec[5] = S_BADA; exp[5] = pack_err(2'd1);
        vec[6] = S_HZD;  exp[6] = pack_err(2'd1);
        vec[7] = S_ASC;
        exp[7] = ASCII_EN ? pack_ok(32'd12345678, 3'd1) : pack_err(2'd1);
        for (int t = 0; t < 8; t++) begin
            run_conv(vec[t], lat, bcnt, d0);
            checks++;
            if (lat != 17) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d required 17", t, lat);
            end
            checks++;
            if (bcnt != 17) begin
                errors++;
                $display("FAIL directed_busy[%0d]: got %0d cycles required 17", t, bcnt);
            end
            checks++;
            if (res_a !== exp[t]) begin
                errors++;
                $display("FAIL directed_a[%0d]: got %h required %h", t, res_a, exp[t]);
            end
            checks++;
            if (res_b !== exp[t]) begin
                errors++;
                $display("FAIL directed_b[%0d]: got %h required %h", t, res_b, exp[t]);
            end
        end
    endtask

    task automatic test_limits;
        int lat, bcnt;
        logic d0;
        run_conv(S_N10, lat, bcnt, d0);
        checks++;
        if (res_a !== pack_err(2'd3)) begin
            errors++;
            $display("FAIL too_many_digits: got %h required %h", res_a, pack_err(2'd3));
        end
        checks++;
        if (res_b !== pack_err(2'd2)) begin
            errors++;
            $display("FAIL overflow: got %h required %h", res_b, pack_err(2'd2));
        end
        run_conv(S_MAX, lat, bcnt, d0);
        checks++;
        if (res_b !== pack_ok(32'hFFFF_FFFF, 3'd0)) begin
            errors++;
            $display("FAIL max_value: got %h required %h", res_b, pack_ok(32'hFFFF_FFFF, 3'd0));
        end
        checks++;
        if (res_a !== pack_err(2'd3)) begin
            errors++;
            $display("FAIL max_value_8dig: got %h required %h", res_a, pack_err(2'd3));
        end
        checks++;
        if (lat != 17) begin
            errors++;
            $display("FAIL limits_latency: got %0d required 17", lat);
        end
    endtask

    task automatic test_random;
        logic [7:0]   q[$];
        logic [127:0] ci;
        logic [37:0]  ea, eb;
        int n, sep, pad, lat, bcnt, d;
        logic d0;
        for (int it = 0; it < 80; it++) begin
            q.delete();
            sep = 0;
            n = $urandom_range(0, 10);
            for (int i = 0; i < n; i++) begin
                if (sep < 2 && $urandom_range(0, 5) == 0) begin
                    q.push_back(8'h5F);
                    sep++;
                end
                d = $urandom_range(0, 9);
                q.push_back(($urandom_range(0, 7) == 0) ? 8'(48 + d) : 8'(d));
            end
            case ($urandom_range(0, 7))
                1: begin q.push_back(8'h48); q.push_back(8'h7A); end
                2: begin q.push_back(8'h6E); q.push_back(8'h73); end
                3: begin q.push_back(8'h75); q.push_back(8'h73); end
                4: q.push_back(8'h25);
                5: begin q.push_back(8'h75); q.push_back(8'h03); q.push_back(8'h73); end
                6: begin q.push_back(8'h48); q.push_back(8'h7A); q.push_back(8'h73); end
                default: ;
            endcase
            pad = 16 - q.size();
            for (int k = 15; k >= 0; k--)
                ci[8*k +: 8] = (15 - k < pad) ? 8'h20 : q[15 - k - pad];
            if ($urandom_range(0, 9) == 0)
                ci[8*$urandom_range(0, 15) +: 8] = 8'($urandom_range(0, 255));
            ea = model(ci, 8);
            eb = model(ci, 10);
            run_conv(ci, lat, bcnt, d0);
            checks++;
            if (lat != 17) begin
                errors++;
                $display("FAIL random_latency[%0d]: got %0d required 17", it, lat);
            end
            checks++;
            if (res_a !== ea) begin
                errors++;
                $display("FAIL random_a[%0d] in=%h: got %h required %h", it, ci, res_a, ea);
            end
            checks++;
            if (res_b !== eb) begin
                errors++;
                $display("FAIL random_b[%0d] in=%h: got %h required %h", it, ci, res_b, eb);
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        int ndone = 0;
        int lat, bcnt;
        logic d0;
        start   = 1'b1;
        char_in = S_NS;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, res_a, busy_b, done_b, res_b} !== 80'd0) begin
            errors++;
            $display("FAIL reset_mid_scan: got %h/%h required 0", res_a, res_b);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done_a || done_b) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d pulses required 0", ndone);
        end
        run_conv(S_US, lat, bcnt, d0);
        checks++;
        if (res_a !== pack_ok(32'd42, 3'd6) || lat != 17) begin
            errors++;
            $display("FAIL after_reset: got %h lat %0d required %h lat 17",
                     res_a, lat, pack_ok(32'd42, 3'd6));
        end
    endtask

    task automatic test_start_while_busy;
        int ndone = 0;
        int first = -1;
        logic [37:0] got = '0;
        start   = 1'b1;
        char_in = S_HZ;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (done_a) begin
                ndone++;
                if (first < 0) begin
                    first = i;
                    got   = res_a;
                end
            end
            start = (i == 5 || i == 16);
            if (start) char_in = S_US;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL busy_start_done_count: got %0d required 1", ndone);
        end
        checks++;
        if (first != 17 || got !== pack_ok(32'd1234567, 3'd1)) begin
            errors++;
            $display("FAIL busy_start_result: got %h at %0d required %h at 17",
                     got, first, pack_ok(32'd1234567, 3'd1));
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle: got busy=%b required 0", busy_a);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bcnt;
        logic d0;
        run_conv(S_NS, lat, bcnt, d0);
        run_conv(S_PCT, lat, bcnt, d0);
        checks++;
        if (d0 !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b after E18 required 0", d0);
        end
        checks++;
        if (lat != 17 || bcnt != 17) begin
            errors++;
            $display("FAIL back_to_back: got lat %0d busy %0d required 17/17", lat, bcnt);
        end
        checks++;
        if (res_a !== pack_ok(32'd42, 3'd7)) begin
            errors++;
            $display("FAIL back_to_back_result: got %h required %h", res_a, pack_ok(32'd42, 3'd7));
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (res_a !== pack_ok(32'd42, 3'd7) || done_a !== 1'b0) begin
            errors++;
            $display("FAIL hold_outputs: got %h done %b required %h done 0",
                     res_a, done_a, pack_ok(32'd42, 3'd7));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_limits();
        test_random();
        test_reset_mid_scan();
        test_start_while_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
